mio_bus_arbiter: RTL

- Shares one single-port memory/IO bus between two requesters: the multi-cycle CPU (requester 0, driven by its CPU_MIO/mem_w/Addr_out/Data_out signals) and a secondary bus master (requester 1, e.g. a DMA or display fetch unit).
- Arbitrates round-robin, sequences fixed-latency memory accesses with a wait-state counter, and returns a one-cycle ready pulse plus read data.
- The ready pulse to requester 0 is the CPU's MIO_ready.

---
 rtl/mio_bus_pkg.sv | 16 +
 rtl/mio_bus_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mio_bus_pkg.sv
// Shared definitions for the memory/IO bus: arbiter state encoding,
// requester indices and the width of the wait-state counter.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_RSVD   = 2'd3
  } bus_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_DEV = 1;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory/IO bus between the
// multi-cycle CPU (requester 0) and a secondary bus master (requester 1).
module mio_bus_arbiter
  import mio_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic [1:0]        state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  bus_state_e        state_r, state_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [1:0]        grant_r, grant_n;
  logic              last_dev_r, last_dev_n;
  logic              we_r, we_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [DATA_W-1:0] wdata_r, wdata_n;
  logic [DATA_W-1:0] rdata_r, rdata_n;
  logic              pick_dev;

  // State and datapath registers; last_dev resets high so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      grant_r    <= 2'b00;
      last_dev_r <= 1'b1;
      we_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      grant_r    <= grant_n;
      last_dev_r <= last_dev_n;
      we_r       <= we_n;
      addr_r     <= addr_n;
      wdata_r    <= wdata_n;
      rdata_r    <= rdata_n;
    end
  end

  // Next-state, arbitration and operand capture.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    grant_n    = grant_r;
    last_dev_n = last_dev_r;
    we_n       = we_r;
    addr_n     = addr_r;
    wdata_n    = wdata_r;
    rdata_n    = rdata_r;
    pick_dev   = dev_req && (!cpu_req || !last_dev_r);
    case (state_r)
      ST_IDLE: begin
        if (cpu_req || dev_req) begin
          state_n    = ST_ACCESS;
          cnt_n      = CNT_LOAD;
          last_dev_n = pick_dev;
          if (pick_dev) begin
            grant_n = 2'b10;
            we_n    = dev_we;
            addr_n  = dev_addr;
            wdata_n = dev_wdata;
          end else begin
            grant_n = 2'b01;
            we_n    = cpu_we;
            addr_n  = cpu_addr;
            wdata_n = cpu_wdata;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_n = ST_DONE;
          // Writes leave the last read value visible.
          if (!we_r) begin
            rdata_n = mem_rdata;
          end else begin
            rdata_n = rdata_r;
          end
        end else begin
          cnt_n = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        grant_n = 2'b00;
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = 2'b00;
      end
    endcase
  end

  assign mem_en    = (state_r == ST_ACCESS);
  assign mem_w     = (state_r == ST_ACCESS) && we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign rdata     = rdata_r;
  assign grant     = grant_r;
  assign state     = state_r;
  assign cpu_ready = (state_r == ST_DONE) && grant_r[REQ_CPU];
  assign dev_ready = (state_r == ST_DONE) && grant_r[REQ_DEV];

endmodule
